// File: rtl/shift_ctrl.sv
// Multi-cycle shift controller: read A, read B, shift, write back.
// Optional zFlag/nFlag outputs when SHIFT_FLAGS_EN is defined.
module shift_ctrl #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [2:0]        opcode,
  input  logic [RA_W-1:0]   srcA,
  input  logic [RA_W-1:0]   srcB,
  input  logic [RA_W-1:0]   dst,
  output logic [RA_W-1:0]   rfAddr,
  input  logic [DATA_W-1:0] rfRdData,
  output logic [DATA_W-1:0] shIn,
  output logic [DATA_W-1:0] shVal,
  output logic [2:0]        shCmd,
  input  logic [DATA_W-1:0] shOut,
  output logic              rfWe,
  output logic [RA_W-1:0]   rfWrAddr,
  output logic [DATA_W-1:0] rfWrData,
  output logic              done
`ifdef SHIFT_FLAGS_EN
  ,
  output logic              zFlag,
  output logic              nFlag
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] WB   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        r_op;
  logic [RA_W-1:0]   r_srcA;
  logic [RA_W-1:0]   r_srcB;
  logic [RA_W-1:0]   r_dst;
  logic [DATA_W-1:0] r_opA;
  logic [DATA_W-1:0] r_opB;
  logic [DATA_W-1:0] r_shIn;
  logic [2:0]        r_shCmd;
  logic [DATA_W-1:0] r_result;

  logic w_rd_a;
  logic w_rd_b;
  logic w_wb;

  assign w_rd_a = (r_state == RD_A);
  assign w_rd_b = (r_state == RD_B);
  assign w_wb   = (r_state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_srcA   <= '0;
      r_srcB   <= '0;
      r_dst    <= '0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_shIn   <= '0;
      r_shCmd  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_srcA  <= srcA;
            r_srcB  <= srcB;
            r_dst   <= dst;
            r_state <= RD_A;
          end
        end
        RD_A: begin
          r_opA   <= rfRdData;
          r_state <= RD_B;
        end
        RD_B: begin
          // Shifter operands change only on EXEC entry so they hold otherwise.
          r_opB   <= rfRdData;
          r_shIn  <= r_opA;
          r_shCmd <= r_op;
          r_state <= EXEC;
        end
        EXEC: begin
          r_result <= shOut;
          r_state  <= WB;
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zFlag <= 1'b0;
      nFlag <= 1'b0;
    end else if (r_state == EXEC) begin
      zFlag <= (shOut == '0);
      nFlag <= shOut[DATA_W-1];
    end
  end
`endif

  assign ready    = (r_state == IDLE);
  assign rfAddr   = w_rd_a ? r_srcA :
                    w_rd_b ? r_srcB : '0;
  assign shIn     = r_shIn;
  assign shVal    = r_opB;
  assign shCmd    = r_shCmd;
  assign rfWe     = w_wb;
  assign done     = w_wb;
  assign rfWrAddr = w_wb ? r_dst : '0;
  assign rfWrData = w_wb ? r_result : '0;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized self-checking bench for shift_ctrl with a behavioural
// register file and shifter; define SHIFT_FLAGS_EN to check flags too.
module tb_shift_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [2:0] opcode;
  logic [2:0] srcA;
  logic [2:0] srcB;
  logic [2:0] dst;
  logic [2:0] rfAddr;
  logic [7:0] rfRdData;
  logic [7:0] shIn;
  logic [7:0] shVal;
  logic [2:0] shCmd;
  logic [7:0] shOut;
  logic       rfWe;
  logic [2:0] rfWrAddr;
  logic [7:0] rfWrData;
  logic       done;
`ifdef SHIFT_FLAGS_EN
  logic       zFlag;
  logic       nFlag;
`endif

  logic [7:0] rf [8];
  int n_chk;
  int n_pass;

  shift_ctrl #(.DATA_W(8), .RA_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .opcode(opcode), .srcA(srcA), .srcB(srcB), .dst(dst),
    .rfAddr(rfAddr), .rfRdData(rfRdData),
    .shIn(shIn), .shVal(shVal), .shCmd(shCmd), .shOut(shOut),
    .rfWe(rfWe), .rfWrAddr(rfWrAddr), .rfWrData(rfWrData),
    .done(done)
`ifdef SHIFT_FLAGS_EN
    , .zFlag(zFlag), .nFlag(nFlag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift semantics from the command table; amounts are not clamped.
  function automatic logic [7:0] shf(input logic [2:0] c,
                                     input logic [7:0] x,
                                     input logic [7:0] n);
    int v;
    int k;
    int r;
    v = int'(x);
    k = int'(n) % 8;
    r = v;
    case (c)
      3'd1: r = (n >= 8) ? 0 : v / (1 << n);
      3'd2: begin
        if (v >= 128) v = v - 256;
        if (n >= 8) r = (v < 0) ? -1 : 0;
        else if (v >= 0) r = v / (1 << n);
        else r = -((-v + (1 << n) - 1) / (1 << n));
      end
      3'd3: r = (v >> k) | (v << (8 - k));
      3'd4: r = (v << k) | (v >> (8 - k));
      3'd5: r = (n >= 8) ? 0 : v * (1 << n);
      default: r = v;
    endcase
    return 8'(r);
  endfunction

  assign rfRdData = rf[rfAddr];
  assign shOut    = shf(shCmd, shIn, shVal);

  always @(posedge clk)
    if (rfWe) rf[rfWrAddr] <= rfWrData;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d);
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] e;
    @(negedge clk);
    va = rf[a];
    vb = rf[b];
    e  = shf(op, va, vb);
    start = 1'b1; opcode = op; srcA = a; srcB = b; dst = d;
    tick();
    start = 1'b0;
    opcode = 3'($urandom); srcA = 3'($urandom);
    srcB = 3'($urandom); dst = 3'($urandom);
    check("rda_addr", rfAddr, a);
    check("busy", ready, 0);
    tick();
    check("rdb_addr", rfAddr, b);
    tick();
    check("ex_shin", shIn, va);
    check("ex_shval", shVal, vb);
    check("ex_shcmd", shCmd, op);
    check("ex_nowe", rfWe, 0);
    tick();
    check("wb_we", rfWe, 1);
    check("wb_done", done, 1);
    check("wb_addr", rfWrAddr, d);
    check("wb_data", rfWrData, e);
    check("wb_rdaddr", rfAddr, 0);
`ifdef SHIFT_FLAGS_EN
    check("zflag", zFlag, (e == 0));
    check("nflag", nFlag, e[7]);
`endif
    tick();
    check("idle_rdy", ready, 1);
    check("idle_done", done, 0);
    check("rf_upd", rf[d], e);
    check("hold_shin", shIn, va);
  endtask

  initial begin
    logic [2:0] wa [4];
    logic [7:0] wd [4];
    int nw;
    int seen;
    logic [7:0] keep;
    n_chk = 0;
    n_pass = 0;
    start = 0; opcode = 0; srcA = 0; srcB = 0; dst = 0;
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    rst_n = 0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_rfaddr", rfAddr, 0);
    check("rst_shin", shIn, 0);
    check("rst_shval", shVal, 0);
    check("rst_shcmd", shCmd, 0);
    check("rst_we", rfWe, 0);
    check("rst_waddr", rfWrAddr, 0);
    check("rst_wdata", rfWrData, 0);
    check("rst_done", done, 0);
`ifdef SHIFT_FLAGS_EN
    check("rst_z", zFlag, 0);
    check("rst_n", nFlag, 0);
`endif
    @(negedge clk);
    rst_n = 1;

    rf[1] = 8'h96; rf[2] = 8'h02;
    run_op(3'b101, 3'd1, 3'd2, 3'd3);
    check("lsl_vec", rf[3], 8'h58);
    rf[1] = 8'h90; rf[2] = 8'h03;
    run_op(3'b010, 3'd1, 3'd2, 3'd3);
    check("asr_vec", rf[3], 8'hF2);
    rf[1] = 8'h81; rf[2] = 8'h01;
    run_op(3'b100, 3'd1, 3'd2, 3'd3);
    check("rol_vec", rf[3], 8'h03);
    rf[1] = 8'h01; rf[2] = 8'h01;
    run_op(3'b001, 3'd1, 3'd2, 3'd3);
    check("lsr_zero", rf[3], 8'h00);
    rf[5] = 8'hC3; rf[6] = 8'd11;
    run_op(3'b101, 3'd5, 3'd6, 3'd5);
    run_op(3'b110, 3'd6, 3'd6, 3'd6);

    // Held start: two accepts, the second with the changed opcode/dst.
    rf[1] = 8'h96; rf[2] = 8'h02;
    nw = 0;
    @(negedge clk);
    start = 1; opcode = 3'b101; srcA = 1; srcB = 2; dst = 3;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 0) begin opcode = 3'b010; dst = 4; end
      if (i == 9) start = 0;
      if (rfWe) begin
        if (nw < 4) begin wa[nw] = rfWrAddr; wd[nw] = rfWrData; end
        nw++;
      end
    end
    check("hold_nwr", nw, 2);
    check("hold_a0", wa[0], 3);
    check("hold_d0", wd[0], 8'h58);
    check("hold_a1", wa[1], 4);
    check("hold_d1", wd[1], 8'hE5);

    // Reset in EXEC abandons the instruction.
    rf[1] = 8'h5A; rf[2] = 8'h01;
    keep = rf[7];
    @(negedge clk);
    start = 1; opcode = 3'b101; srcA = 1; srcB = 2; dst = 7;
    tick();
    start = 0;
    tick();
    tick();
    check("pre_rst_cmd", shCmd, 3'b101);
    #2 rst_n = 0;
    #1;
    check("mid_ready", ready, 1);
    check("mid_rfaddr", rfAddr, 0);
    check("mid_shin", shIn, 0);
    check("mid_shval", shVal, 0);
    check("mid_shcmd", shCmd, 0);
    check("mid_we", rfWe, 0);
    check("mid_done", done, 0);
    check("mid_wdata", rfWrData, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rfWe || done) seen++;
    end
    check("rst_nowr", seen, 0);
    check("rst_keep", rf[7], keep);

    for (int t = 0; t < 40; t++)
      run_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
